// File: rtl/pwm_sched_queue.sv
// ============================================================================
// pwm_sched_queue : timestamped PWM update FIFO; releases each entry as a
//                   one-cycle strobe when systime reaches its timestamp.
//                   Optional counters enabled by `define PWM_SCHED_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sched_queue #(
    parameter int NPWM        = 12,
    parameter int PWM_BITS    = 26,
    parameter int DEPTH       = 8,
    parameter int LATE_WINDOW = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               systime,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NPWM)-1:0]   in_channel,
    input  logic [31:0]               in_time,
    input  logic [PWM_BITS-1:0]       in_value,
    output logic                      in_reject,
    output logic                      upd_valid,
    output logic [$clog2(NPWM)-1:0]   upd_channel,
    output logic [PWM_BITS-1:0]       upd_value,
    output logic                      late,
    output logic [$clog2(DEPTH):0]    count
`ifdef PWM_SCHED_STATS_EN
    ,
    output logic [15:0]               late_cnt,
    output logic [15:0]               reject_cnt
`endif
);

    localparam int C_CHW  = $clog2(NPWM);
    localparam int C_AW   = $clog2(DEPTH);
    localparam int C_CNTW = C_AW + 1;
    localparam logic [C_CHW:0]       C_NPWM     = (C_CHW + 1)'(NPWM);
    localparam logic [C_CNTW-1:0]    C_DEPTH    = C_CNTW'(DEPTH);
    localparam logic signed [31:0]   C_LATE_WIN = 32'(LATE_WINDOW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [C_CHW-1:0]    r_mem_ch   [DEPTH];
    logic [PWM_BITS-1:0] r_mem_val  [DEPTH];
    logic [31:0]         r_mem_time [DEPTH];

    logic [C_AW-1:0]     r_wr_ptr;
    logic [C_AW-1:0]     r_rd_ptr;
    logic [C_CNTW-1:0]   r_count;
    logic [31:0]         r_last_time;

    logic [31:0]         w_head_diff;
    logic                w_due;
    logic                w_late;
    logic                w_drop;
    logic                w_pop;
    logic                w_hs;
    logic                w_chan_ok;
    logic                w_order_ok;
    logic                w_push;
    logic                w_refuse;
    logic [C_CNTW-1:0]   w_count_next;

    // Wrap-aware distance of systime past the head timestamp
    assign w_head_diff = systime - r_mem_time[r_rd_ptr];
    assign w_due       = $signed(w_head_diff) >= 0;
    assign w_late      = $signed(w_head_diff) > C_LATE_WIN;

    assign w_drop = (r_state == ST_WAIT) && w_late;
    assign w_pop  = (r_state == ST_ISSUE) || w_drop;

    // A slot freed by this cycle's pop can be refilled in the same cycle
    assign in_ready   = (r_count < C_DEPTH) || w_pop;
    assign w_hs       = in_valid && in_ready;
    assign w_chan_ok  = {1'b0, in_channel} < C_NPWM;
    assign w_order_ok = (r_count == '0) || ($signed(in_time - r_last_time) >= 0);
    assign w_push     = w_hs && w_chan_ok && w_order_ok;
    assign w_refuse   = w_hs && !(w_chan_ok && w_order_ok);
    assign count      = r_count;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // A drop returns through IDLE so drops are spaced like issues
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_late)     w_state_next = ST_IDLE;
                else if (w_due) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_next = (w_count_next != '0) ? ST_WAIT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_time <= '0;
            in_reject   <= 1'b0;
            upd_valid   <= 1'b0;
            late        <= 1'b0;
            upd_channel <= '0;
            upd_value   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            in_reject <= w_refuse;
            late      <= w_drop;
            upd_valid <= (r_state == ST_ISSUE);
            if (r_state == ST_ISSUE) begin
                upd_channel <= r_mem_ch[r_rd_ptr];
                upd_value   <= r_mem_val[r_rd_ptr];
            end
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_last_time <= in_time;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ch[r_wr_ptr]   <= in_channel;
            r_mem_val[r_wr_ptr]  <= in_value;
            r_mem_time[r_wr_ptr] <= in_time;
        end
    end

`ifdef PWM_SCHED_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            late_cnt   <= '0;
            reject_cnt <= '0;
        end else begin
            if (w_drop && (late_cnt != 16'hFFFF))     late_cnt   <= late_cnt + 1'b1;
            if (w_refuse && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_sched_queue.sv
// ============================================================================
// tb_pwm_sched_queue : directed scenarios plus randomized traffic checked
//                      against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_sched_queue;

    localparam int NPWM     = 12;
    localparam int PWM_BITS = 26;
    localparam int DEPTH    = 8;
    localparam int LW       = 1000;
    localparam int CHW      = $clog2(NPWM);
    localparam int CNTW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [CHW-1:0]      ch;
        logic [PWM_BITS-1:0] val;
        logic [31:0]         t;
    } ent_t;

    logic                clk        = 1'b0;
    logic                rst        = 1'b1;
    logic [31:0]         systime    = '0;
    logic                in_valid   = 1'b0;
    logic [CHW-1:0]      in_channel = '0;
    logic [31:0]         in_time    = '0;
    logic [PWM_BITS-1:0] in_value   = '0;
    logic                in_ready;
    logic                in_reject;
    logic                upd_valid;
    logic [CHW-1:0]      upd_channel;
    logic [PWM_BITS-1:0] upd_value;
    logic                late;
    logic [CNTW-1:0]     count;
`ifdef PWM_SCHED_STATS_EN
    logic [15:0]         late_cnt;
    logic [15:0]         reject_cnt;
`endif

    int total = 0;
    int bad   = 0;

    pwm_sched_queue #(
        .NPWM(NPWM), .PWM_BITS(PWM_BITS), .DEPTH(DEPTH), .LATE_WINDOW(LW)
    ) dut (
        .clk(clk), .rst(rst), .systime(systime),
        .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
        .in_time(in_time), .in_value(in_value), .in_reject(in_reject),
        .upd_valid(upd_valid), .upd_channel(upd_channel), .upd_value(upd_value),
        .late(late), .count(count)
`ifdef PWM_SCHED_STATS_EN
        , .late_cnt(late_cnt), .reject_cnt(reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One clock: outputs settle just after the edge, then systime advances
    task automatic cyc(input int inc);
        @(posedge clk);
        #1;
        systime = systime + 32'(inc);
    endtask

    task automatic drive(input logic v, input int ch, input logic [31:0] t,
                         input logic [PWM_BITS-1:0] val);
        in_valid   = v;
        in_channel = CHW'(ch);
        in_time    = t;
        in_value   = val;
    endtask

    task automatic do_reset();
        drive(1'b0, 0, '0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_count(input int n, input int inc, output int nu, output int nl);
        nu = 0;
        nl = 0;
        for (int i = 0; i < n; i++) begin
            cyc(inc);
            if (upd_valid === 1'b1) nu++;
            if (late === 1'b1) nl++;
        end
    endtask

    task automatic test_reset();
        int nu, nl;
        do_reset();
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if ({in_reject, upd_valid, late} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {in_reject, upd_valid, late}); end
        total++; if (upd_channel !== '0 || upd_value !== '0) begin bad++; $display("FAIL reset_upd_data got=%0d/%0d want=0/0", upd_channel, upd_value); end
        run_count(3, 1, nu, nl);
        total++; if (nu + nl != 0) begin bad++; $display("FAIL reset_quiet got=%0d want=0", nu + nl); end
    endtask

    task automatic test_basic();
        logic        got = 1'b0;
        logic [31:0] at  = '0;
        do_reset();
        systime = 32'd50;
        drive(1'b1, 3, 32'd100, 26'd500);
        cyc(1);
        drive(1'b0, 0, '0, '0);
        total++; if (count !== CNTW'(1)) begin bad++; $display("FAIL basic_count1 got=%0d want=1", count); end
        for (int i = 0; i < 200; i++) begin
            if (upd_valid === 1'b1) begin
                got = 1'b1;
                at  = systime;
                break;
            end
            cyc(1);
        end
        total++; if (got !== 1'b1 || at !== 32'd102) begin bad++; $display("FAIL basic_latency got=%0d(seen %b) want=102", at, got); end
        total++; if (upd_channel !== CHW'(3) || upd_value !== PWM_BITS'(500)) begin bad++; $display("FAIL basic_data got=%0d/%0d want=3/500", upd_channel, upd_value); end
        cyc(1);
        total++; if (upd_valid !== 1'b0 || count !== '0) begin bad++; $display("FAIL basic_after got=%b/%0d want=0/0", upd_valid, count); end
        total++; if (upd_channel !== CHW'(3) || upd_value !== PWM_BITS'(500)) begin bad++; $display("FAIL basic_hold got=%0d/%0d want=3/500", upd_channel, upd_value); end
    endtask

    task automatic test_order();
        int                  n = 0;
        logic [CHW-1:0]      ch = '0;
        logic [PWM_BITS-1:0] v = '0;
        do_reset();
        systime = '0;
        drive(1'b1, 5, 32'd200, 26'd11);
        cyc(1);
        total++; if (in_reject !== 1'b0) begin bad++; $display("FAIL order_first got=%b want=0", in_reject); end
        drive(1'b1, 6, 32'd150, 26'd22);
        cyc(1);
        drive(1'b0, 0, '0, '0);
        total++; if (in_reject !== 1'b1 || count !== CNTW'(1)) begin bad++; $display("FAIL order_reject got=%b/%0d want=1/1", in_reject, count); end
        cyc(1);
        total++; if (in_reject !== 1'b0) begin bad++; $display("FAIL order_pulse got=%b want=0", in_reject); end
        systime = 32'd190;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (upd_valid === 1'b1) begin
                n++;
                ch = upd_channel;
                v  = upd_value;
            end
        end
        total++; if (n != 1 || ch !== CHW'(5) || v !== PWM_BITS'(11)) begin bad++; $display("FAIL order_issue got=%0d x ch%0d v%0d want=1 x ch5 v11", n, ch, v); end
        total++; if (count !== '0) begin bad++; $display("FAIL order_empty got=%0d want=0", count); end
    endtask

    task automatic test_full();
        int   exp_ch [9];
        int   idx    = 1;
        logic rdy_ok = 1'b1;
        logic pushed = 1'b0;
        do_reset();
        systime = '0;
        for (int i = 0; i < 8; i++) begin
            exp_ch[i] = i % 3;
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            drive(1'b1, i % 3, 32'(1000 + i), PWM_BITS'(100 + i));
            cyc(1);
        end
        exp_ch[8] = 2;
        drive(1'b0, 0, '0, '0);
        total++; if (rdy_ok !== 1'b1) begin bad++; $display("FAIL full_ready_fill got=0 want=1"); end
        total++; if (count !== CNTW'(8) || in_ready !== 1'b0) begin bad++; $display("FAIL full_state got=%0d/%b want=8/0", count, in_ready); end
        drive(1'b1, 1, 32'd1010, 26'd999);
        cyc(1);
        drive(1'b0, 0, '0, '0);
        total++; if (count !== CNTW'(8) || in_reject !== 1'b0) begin bad++; $display("FAIL full_ninth got=%0d/%b want=8/0", count, in_reject); end
        systime = 32'd1000;
        for (int i = 0; i < 10; i++) begin
            if (in_ready === 1'b1) begin
                drive(1'b1, 2, 32'd1008, 26'd108);
                cyc(1);
                drive(1'b0, 0, '0, '0);
                pushed = 1'b1;
                break;
            end
            cyc(1);
        end
        total++; if (pushed !== 1'b1) begin bad++; $display("FAIL full_ready_on_pop got=0 want=1"); end
        total++; if (count !== CNTW'(8) || in_reject !== 1'b0) begin bad++; $display("FAIL full_push_pop got=%0d/%b want=8/0", count, in_reject); end
        total++; if (upd_valid !== 1'b1 || upd_value !== PWM_BITS'(100) || upd_channel !== CHW'(0)) begin bad++; $display("FAIL full_first got=%b/%0d/%0d want=1/0/100", upd_valid, upd_channel, upd_value); end
        for (int i = 0; i < 60 && idx < 9; i++) begin
            cyc(1);
            if (upd_valid === 1'b1) begin
                total++;
                if (upd_value !== PWM_BITS'(100 + idx) || upd_channel !== CHW'(exp_ch[idx])) begin
                    bad++;
                    $display("FAIL full_order[%0d] got=%0d/%0d want=%0d/%0d", idx, upd_channel, upd_value, exp_ch[idx], 100 + idx);
                end
                idx++;
            end
        end
        cyc(1);
        total++; if (idx != 9 || count !== '0) begin bad++; $display("FAIL full_drain got=%0d/%0d want=9/0", idx, count); end
    endtask

    task automatic test_late();
        logic [31:0] st_tbl [5] = '{32'd2000, 32'd500, 32'd1010, 32'd1011, 32'd10};
        int          lt_tbl [5] = '{1, 0, 0, 1, 0};
        int nu, nl;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            systime = st_tbl[k];
            drive(1'b1, 1, 32'd10, PWM_BITS'(77 + k));
            cyc(0);
            drive(1'b0, 0, '0, '0);
            run_count(8, 0, nu, nl);
            total++;
            if (nl != lt_tbl[k] || nu != 1 - lt_tbl[k] || count !== '0) begin
                bad++;
                $display("FAIL late_case[%0d] got=late%0d upd%0d cnt%0d want=late%0d upd%0d cnt0",
                         k, nl, nu, count, lt_tbl[k], 1 - lt_tbl[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0]         at [2];
        logic [PWM_BITS-1:0] vv [2];
        int n = 0;
        do_reset();
        systime = 32'hFFFF_FFF0;
        drive(1'b1, 2, 32'h0000_0005, 26'd55);
        cyc(1);
        total++; if (in_reject !== 1'b0) begin bad++; $display("FAIL wrap_rej1 got=%b want=0", in_reject); end
        drive(1'b1, 4, 32'h0000_0008, 26'd88);
        cyc(1);
        drive(1'b0, 0, '0, '0);
        total++; if (in_reject !== 1'b0 || count !== CNTW'(2)) begin bad++; $display("FAIL wrap_rej2 got=%b/%0d want=0/2", in_reject, count); end
        for (int i = 0; i < 60; i++) begin
            if (upd_valid === 1'b1) begin
                at[n] = systime;
                vv[n] = upd_value;
                n++;
                if (n == 2) break;
            end
            cyc(1);
        end
        total++; if (n != 2) begin bad++; $display("FAIL wrap_issued got=%0d want=2", n); end
        else begin
            total++; if (at[0] !== 32'd7 || vv[0] !== PWM_BITS'(55)) begin bad++; $display("FAIL wrap_first got=t%0d v%0d want=t7 v55", at[0], vv[0]); end
            total++; if (at[1] !== 32'd10 || vv[1] !== PWM_BITS'(88)) begin bad++; $display("FAIL wrap_second got=t%0d v%0d want=t10 v88", at[1], vv[1]); end
        end
    endtask

    task automatic test_reset_midop();
        int nu, nl;
        do_reset();
        systime = 32'd100;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 32'(300 + i), PWM_BITS'(i + 1));
            cyc(1);
        end
        drive(1'b0, 0, '0, '0);
        total++; if (count !== CNTW'(4)) begin bad++; $display("FAIL midrst_fill got=%0d want=4", count); end
        #2 rst = 1'b1;
        #1;
        total++; if (count !== '0 || in_ready !== 1'b1) begin bad++; $display("FAIL midrst_async got=%0d/%b want=0/1", count, in_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        systime = 32'd400;
        run_count(20, 1, nu, nl);
        total++; if (nu + nl != 0 || count !== '0) begin bad++; $display("FAIL midrst_quiet got=%0d ev cnt%0d want=0 ev cnt0", nu + nl, count); end
    endtask

    task automatic test_random();
        ent_t                mq[$];
        ent_t                e;
        logic [31:0]         st1, st2, t, d, last_t;
        logic [CHW-1:0]      hold_ch;
        logic [PWM_BITS-1:0] hold_v;
        logic                hs, acc;
        int                  ch, off, sel, i;
        do_reset();
        systime = $urandom;
        st1 = systime; st2 = systime; last_t = '0;
        hold_ch = '0; hold_v = '0;
        i = 0;
        while (i < 700 && !(i >= 500 && mq.size() == 0)) begin
            hs  = 1'b0;
            acc = 1'b0;
            if (i < 500 && mq.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                ch  = int'($urandom_range(0, 15));
                sel = int'($urandom_range(0, 9));
                if (sel == 0)     off = -int'($urandom_range(1001, 1500));
                else if (sel < 4) off = -int'($urandom_range(0, 900));
                else              off = int'($urandom_range(0, 12));
                t = systime + 32'(off);
                e.ch = CHW'(ch); e.val = PWM_BITS'($urandom); e.t = t;
                drive(1'b1, ch, t, e.val);
                hs  = 1'b1;
                d   = t - last_t;
                acc = (ch < NPWM) && (mq.size() == 0 || $signed(d) >= 0);
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b want=1", i, in_ready); end
            end else begin
                drive(1'b0, 0, '0, '0);
            end
            st2 = st1;
            st1 = systime;
            cyc(1);
            total++; if (in_reject !== (hs && !acc)) begin bad++; $display("FAIL rnd_reject[%0d] got=%b want=%b", i, in_reject, hs && !acc); end
            total++; if ((upd_valid && late) !== 1'b0) begin bad++; $display("FAIL rnd_both[%0d] got=1 want=0", i); end
            if (upd_valid === 1'b1 || late === 1'b1) begin
                total++;
                if (mq.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_spurious[%0d] got=event want=none", i);
                end else begin
                    ent_t h;
                    h = mq.pop_front();
                    if (upd_valid === 1'b1) begin
                        d = st2 - h.t;
                        if (upd_channel !== h.ch || upd_value !== h.val || $signed(d) < 0 || $signed(d) > LW) begin
                            bad++;
                            $display("FAIL rnd_issue[%0d] got=ch%0d v%0d d%0d want=ch%0d v%0d d0..%0d",
                                     i, upd_channel, upd_value, $signed(d), h.ch, h.val, LW);
                        end
                        hold_ch = h.ch;
                        hold_v  = h.val;
                    end else begin
                        d = st1 - h.t;
                        if ($signed(d) <= LW) begin
                            bad++;
                            $display("FAIL rnd_late[%0d] got=d%0d want=d>%0d", i, $signed(d), LW);
                        end
                    end
                end
            end else begin
                total++;
                if (upd_channel !== hold_ch || upd_value !== hold_v) begin
                    bad++;
                    $display("FAIL rnd_hold[%0d] got=%0d/%0d want=%0d/%0d", i, upd_channel, upd_value, hold_ch, hold_v);
                end
            end
            if (acc) begin
                mq.push_back(e);
                last_t = e.t;
            end
            total++; if (count !== CNTW'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, count, mq.size()); end
            i++;
        end
        drive(1'b0, 0, '0, '0);
        total++; if (mq.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d left want=0", mq.size()); end
    endtask

`ifdef PWM_SCHED_STATS_EN
    task automatic test_stats();
        int nu, nl;
        do_reset();
        total++; if (late_cnt !== '0 || reject_cnt !== '0) begin bad++; $display("FAIL stats_reset got=%0d/%0d want=0/0", late_cnt, reject_cnt); end
        systime = 32'd5000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 32'd10, PWM_BITS'(i));
            cyc(0);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 13, 32'd10, PWM_BITS'(i));
            cyc(0);
        end
        drive(1'b0, 0, '0, '0);
        run_count(12, 0, nu, nl);
        total++; if (late_cnt !== 16'd3 || reject_cnt !== 16'd2) begin bad++; $display("FAIL stats_counts got=%0d/%0d want=3/2", late_cnt, reject_cnt); end
        #2 rst = 1'b1;
        #1;
        total++; if (late_cnt !== '0 || reject_cnt !== '0) begin bad++; $display("FAIL stats_clear got=%0d/%0d want=0/0", late_cnt, reject_cnt); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_full();
        test_late();
        test_wrap();
        test_reset_midop();
        test_random();
`ifdef PWM_SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
